// File: rtl/lfsr_word_packer_if.sv
// rtl/lfsr_word_packer_if.sv - serial bit input and packed word output bundle for lfsr_word_packer
//
// Signals:
//   bit_in, bit_valid  : serial pseudo-random bit stream from the upstream LFSR
//   word_data          : head word of the output FIFO
//   word_valid         : the FIFO holds at least one word
//   word_ready         : the consumer takes the head word when word_valid is also high
//   fifo_level         : number of words currently stored
//   overflow           : sticky flag, a completed word was dropped
// Modports: master drives bits and word_ready; slave is the packer.
interface lfsr_word_packer_if #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                            bit_in;
    logic                            bit_valid;
    logic [WORD_W-1:0]               word_data;
    logic                            word_valid;
    logic                            word_ready;
    logic [$clog2(FIFO_DEPTH):0]     fifo_level;
    logic                            overflow;

    modport master (
        output bit_in,
        output bit_valid,
        output word_ready,
        input  word_data,
        input  word_valid,
        input  fifo_level,
        input  overflow
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        input  word_ready,
        output word_data,
        output word_valid,
        output fifo_level,
        output overflow
    );
endinterface

// File: rtl/lfsr_word_packer.sv
// rtl/lfsr_word_packer.sv - packs a serial LFSR bit stream into words and queues them in a small FIFO
//
// Ports:
//   clk            : single clock, all state changes on its rising edge
//   reset          : synchronous active-low reset
//   enable         : 1 = COLLECT, 0 = IDLE (partial word is held)
//   flush          : discard the partial word (FIFO contents kept)
//   clear_overflow : clear the sticky overflow flag
//   bus            : slave side of lfsr_word_packer_if (bit stream in, word stream out)
module lfsr_word_packer #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 flush,
    input  logic                 clear_overflow,
    lfsr_word_packer_if.slave    bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(WORD_W);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [WORD_W-1:0]   shreg;
    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    level;
    logic                overflow_q;

    logic                sample;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic                do_write;
    logic                drop;
    logic [WORD_W-1:0]   word_next;

    always_comb begin
        sample    = 1'b0;
        push      = 1'b0;
        word_next = {shreg[WORD_W-2:0], bus.bit_in};
        empty     = (level == '0);
        full      = (level == FULL_LVL);
        // A flush on the same edge wins over the incoming bit.
        sample    = (state == COLLECT) && bus.bit_valid && !flush;
        push      = sample && (bit_cnt == LAST_BIT);
        // word_ready only feeds state updates, never the outputs directly.
        pop       = !empty && bus.word_ready;
        // A full FIFO still accepts a word when the head leaves on the same edge.
        do_write  = push && (!full || pop);
        drop      = push && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_q <= 1'b0;
            // Storage is cleared so the head word is never X, even after
            // the read pointer moves onto a slot that was never written.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= enable ? COLLECT : IDLE;

            if (flush) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (sample) begin
                shreg   <= word_next;
                bit_cnt <= push ? '0 : bit_cnt + 1'b1;
            end

            if (do_write) begin
                mem[wr_ptr] <= word_next;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({do_write, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.word_data  = mem[rd_ptr];
    assign bus.word_valid = !empty;
    assign bus.fifo_level = level;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_lfsr_word_packer.sv
// tb/tb_lfsr_word_packer.sv - self-checking scoreboard bench for lfsr_word_packer
module tb_lfsr_word_packer;
    localparam int WORD_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic clk;
    logic reset;
    logic enable;
    logic flush;
    logic clear_overflow;

    int total;
    int bad;

    lfsr_word_packer_if #(.WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    lfsr_word_packer #(.WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .bus            (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: words expected in the FIFO, in order.
    logic [WORD_W-1:0] exp_q[$];
    logic              m_state;
    int                m_cnt;
    logic [WORD_W-1:0] m_sh;
    logic              m_ovf;
    logic              mon_en;

    // At each falling edge: compare DUT outputs with the scoreboard, then
    // advance the scoreboard with the inputs that the next rising edge samples.
    always @(negedge clk) begin
        logic              m_pop;
        logic              m_push;
        logic              m_drop;
        logic [WORD_W-1:0] w;
        if (mon_en) begin
            check("valid", bus.word_valid, exp_q.size() != 0);
            check("level", bus.fifo_level, exp_q.size());
            check("ovf", bus.overflow, m_ovf);
            if (exp_q.size() != 0) check("head", bus.word_data, exp_q[0]);
        end
        if (!reset) begin
            exp_q.delete();
            m_state = 1'b0;
            m_cnt   = 0;
            m_sh    = '0;
            m_ovf   = 1'b0;
        end else begin
            m_pop  = (exp_q.size() != 0) && bus.word_ready;
            m_push = 1'b0;
            m_drop = 1'b0;
            w      = {m_sh[WORD_W-2:0], bus.bit_in};
            if (flush) begin
                m_cnt = 0;
                m_sh  = '0;
            end else if (m_state && bus.bit_valid) begin
                m_sh = w;
                if (m_cnt == WORD_W - 1) begin
                    m_push = 1'b1;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (m_push && exp_q.size() == FIFO_DEPTH && !m_pop) m_drop = 1'b1;
            if (m_pop) void'(exp_q.pop_front());
            if (m_push && !m_drop) exp_q.push_back(w);
            if (m_drop) m_ovf = 1'b1;
            else if (clear_overflow) m_ovf = 1'b0;
            m_state = enable;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [WORD_W-1:0] w, input int n);
        for (int i = WORD_W - 1; i >= WORD_W - n; i--) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = w[i];
            tick();
        end
        bus.bit_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bus.word_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!bus.word_valid) break;
            tick();
        end
        bus.word_ready = 1'b0;
        check(tag, bus.word_valid, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        mon_en = 1'b0;
        reset = 1'b0;
        enable = 1'b0;
        flush = 1'b0;
        clear_overflow = 1'b0;
        bus.bit_in = 1'b0;
        bus.bit_valid = 1'b0;
        bus.word_ready = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        reset = 1'b1;
        check("rst_level", bus.fifo_level, 0);
        check("rst_valid", bus.word_valid, 0);
        check("rst_data", bus.word_data, 0);
        check("rst_ovf", bus.overflow, 0);

        // Basic word: 1,0,1,1,0,0,1,0 -> B2
        enable = 1'b1;
        tick();
        send_bits(8'hB2, 8);
        check("b2_valid", bus.word_valid, 1);
        check("b2_data", bus.word_data, 8'hB2);
        check("b2_level", bus.fifo_level, 1);
        drain("b2_drain");

        // Overflow: five words into a four-deep FIFO
        for (int k = 0; k < 5; k++) send_bits(8'hFF, 8);
        check("ovf_level", bus.fifo_level, 4);
        check("ovf_set", bus.overflow, 1);
        check("ovf_head", bus.word_data, 8'hFF);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("ovf_clear", bus.overflow, 0);

        // Full FIFO: pop and push on the same edge
        send_bits(8'h3C, 7);
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b0;
        bus.word_ready = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
        bus.word_ready = 1'b0;
        check("full_pp_level", bus.fifo_level, 4);
        check("full_pp_ovf", bus.overflow, 0);
        drain("full_drain");

        // Pause mid-word, junk bits while idle must be ignored
        send_bits(8'hA6, 4);
        enable = 1'b0;
        tick();
        for (int k = 0; k < 9; k++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = 1'($urandom_range(0, 1));
            tick();
        end
        bus.bit_valid = 1'b0;
        enable = 1'b1;
        tick();
        send_bits(8'h6A, 4);
        check("pause_level", bus.fifo_level, 1);
        check("pause_data", bus.word_data, 8'hA6);
        drain("pause_drain");

        // Flush discards a partial word and the bit sampled with it
        send_bits(8'hE0, 5);
        flush = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_in = 1'b1;
        tick();
        flush = 1'b0;
        bus.bit_valid = 1'b0;
        check("flush_level", bus.fifo_level, 0);
        send_bits(8'h5A, 8);
        check("flush_level2", bus.fifo_level, 1);
        check("flush_data", bus.word_data, 8'h5A);
        drain("flush_drain");

        // Reset mid-word with two words queued
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        send_bits(8'hE0, 3);
        check("prerst_level", bus.fifo_level, 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mrst_level", bus.fifo_level, 0);
        check("mrst_valid", bus.word_valid, 0);
        check("mrst_data", bus.word_data, 0);
        check("mrst_ovf", bus.overflow, 0);
        tick();
        send_bits(8'hC3, 8);
        check("mrst_level2", bus.fifo_level, 1);
        check("mrst_word", bus.word_data, 8'hC3);
        drain("mrst_drain");

        // Random words with gaps in bit_valid and a random consumer
        for (int k = 0; k < 6; k++) begin
            logic [WORD_W-1:0] rw;
            int sent;
            rw   = WORD_W'($urandom);
            sent = 0;
            while (sent < WORD_W) begin
                bus.bit_valid  = ($urandom_range(0, 3) != 0);
                bus.bit_in     = rw[WORD_W - 1 - sent];
                bus.word_ready = 1'($urandom_range(0, 1));
                tick();
                if (bus.bit_valid) sent++;
            end
            bus.bit_valid = 1'b0;
        end
        drain("rand_drain");
        tick();
        check("end_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
